// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, fetches 9-bit words over a req/ack
// handshake, and issues opcode/arguments to the control unit for one cycle.
module instr_fetch #(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_En,
  input  logic       i_mem_ack,
  input  logic [8:0] i_mem_data,
  input  logic       i_h_s,
  input  logic [7:0] i_dir_sal,
  output logic       o_mem_req,
  output logic [7:0] o_mem_addr,
  output logic [2:0] o_Cod_op,
  output logic [5:0] o_Arguments,
  output logic       o_valid,
  output logic [7:0] o_pc,
  output logic       o_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  localparam logic [2:0] OP_NOP    = 3'b111;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] wait_q, wait_d;
  logic       err_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    wait_d  = wait_q;
    err_d   = o_err;
    unique case (state_q)
      IDLE: begin
        wait_d = 8'd0;
        if (i_En && !o_err) state_d = FETCH;
      end
      FETCH: begin
        // An ack on the final allowed cycle takes precedence over the timeout.
        if (i_mem_ack) begin
          state_d = ISSUE;
          wait_d  = 8'd0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = IDLE;
          wait_d  = 8'd0;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ISSUE: begin
        pc_d    = i_h_s ? i_dir_sal : pc_q + 8'd1;
        state_d = i_En ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge i_Clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (i_Rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      wait_q      <= 8'd0;
      o_err       <= 1'b0;
      o_mem_req   <= 1'b0;
      o_valid     <= 1'b0;
      o_Cod_op    <= OP_NOP;
      o_Arguments <= 6'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      wait_q    <= wait_d;
      o_err     <= err_d;
      o_mem_req <= (state_d == FETCH);
      o_valid   <= (state_d == ISSUE);
      if (state_d == ISSUE) begin
        o_Cod_op    <= i_mem_data[8:6];
        o_Arguments <= i_mem_data[5:0];
      end else begin
        o_Cod_op    <= OP_NOP;
        o_Arguments <= 6'd0;
      end
    end
  end

  assign o_mem_addr = pc_q;
  assign o_pc       = pc_q;

endmodule
